// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions.
//   HIST_W       global history width, equal to the pattern history table index width
//   PHT_ENTRIES  number of pattern history table entries
//   bp_entry_t   in-flight branch record: lookup index plus the prediction returned for it
//   bp_state_t   history controller state (RUN / REPAIR)
package bp_pkg;

    localparam int unsigned HIST_W      = 4;
    localparam int unsigned PHT_ENTRIES = 1 << HIST_W;

    typedef struct packed {
        logic [HIST_W-1:0] idx;
        logic              pt;
    } bp_entry_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REPAIR = 1'b1
    } bp_state_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight branch queue: a DEPTH-deep FIFO of bp_entry_t.
// The head entry is read combinationally. A flush drops every entry at once.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data at the tail (ignored when full)
//   push_data  entry to enqueue
//   pop        drop the head entry (ignored when empty)
//   flush      empty the queue; takes priority over push and pop
//   head       oldest entry (don't-care when empty)
//   count      number of valid entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  bp_entry_t                push_data,
    input  logic                     pop,
    input  logic                     flush,
    output bp_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    bp_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_history_ctrl.sv
// Branch history controller: owns the single index/update port of the pattern
// history table. Fetch looks up with the speculative GHR; in-flight branches are
// queued and resolved in order, each resolution writing the table with its
// original index. A mispredict repairs the speculative GHR from the
// architectural one, flushes the queue and pulses mispredict for one cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pred_valid      fetch presents a branch needing a prediction
//   pred_ready      branch accepted when pred_valid & pred_ready
//   pred_taken      prediction returned to fetch (pht_pre_taken passthrough)
//   res_valid       oldest in-flight branch resolves this cycle
//   res_taken       real outcome of the resolving branch
//   mispredict      registered one-cycle redirect pulse
//   pht_index       table index (head index on resolve, speculative GHR otherwise)
//   pht_update_en   table update strobe
//   pht_real_taken  outcome written to the table counter
//   pht_pre_taken   table prediction for pht_index (combinational)
//   q_err           sticky: resolve seen with an empty queue
module branch_history_ctrl #(
    parameter int unsigned HIST_W = bp_pkg::HIST_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    output logic              pred_ready,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              mispredict,
    output logic [HIST_W-1:0] pht_index,
    output logic              pht_update_en,
    output logic              pht_real_taken,
    input  logic              pht_pre_taken,
    output logic              q_err
);

    import bp_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    bp_state_t         state;
    logic [HIST_W-1:0] spec_ghr;
    logic [HIST_W-1:0] arch_ghr;
    logic [HIST_W-1:0] arch_next;

    bp_entry_t         q_head;
    bp_entry_t         q_push_data;
    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;

    logic              pred_fire;
    logic              res_fire;
    logic              res_mismatch;

    // Resolve owns the shared table port, so it blocks predict acceptance.
    assign pred_ready   = !res_valid && (state == ST_RUN) && !q_full;
    assign pred_taken   = pht_pre_taken;
    assign pred_fire    = pred_valid && pred_ready;
    assign res_fire     = res_valid && !q_empty;
    assign res_mismatch = res_fire && (res_taken != q_head.pt);
    assign arch_next    = {arch_ghr[HIST_W-2:0], res_taken};

    assign q_push_data.idx = spec_ghr;
    assign q_push_data.pt  = pht_pre_taken;

    always_comb begin
        pht_index      = spec_ghr;
        pht_update_en  = 1'b0;
        pht_real_taken = 1'b0;
        if (res_fire) begin
            pht_index      = q_head.idx;
            pht_update_en  = 1'b1;
            pht_real_taken = res_taken;
        end
    end

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pred_fire),
        .push_data (q_push_data),
        .pop       (res_fire),
        .flush     (res_mismatch),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // On a mispredict the repaired speculative history equals the new
    // architectural history, which already includes the resolving outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else begin
            if (res_fire) begin
                arch_ghr <= arch_next;
            end
            if (res_mismatch) begin
                spec_ghr <= arch_next;
            end else if (pred_fire) begin
                spec_ghr <= {spec_ghr[HIST_W-2:0], pht_pre_taken};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_err <= 1'b0;
        end else if (res_valid && (q_count == '0)) begin
            q_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            mispredict <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (res_mismatch) begin
                        state      <= ST_REPAIR;
                        mispredict <= 1'b1;
                    end else begin
                        mispredict <= 1'b0;
                    end
                end
                ST_REPAIR: begin
                    state      <= ST_RUN;
                    mispredict <= 1'b0;
                end
                default: begin
                    state      <= ST_RUN;
                    mispredict <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_history_ctrl.sv
module tb_branch_history_ctrl;

    localparam int unsigned HW    = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pred_valid;
    logic          pred_ready;
    logic          pred_taken;
    logic          res_valid;
    logic          res_taken;
    logic          mispredict;
    logic [HW-1:0] pht_index;
    logic          pht_update_en;
    logic          pht_real_taken;
    logic          pht_pre_taken;
    logic          q_err;

    // Environment table: either a fixed random bit pattern or a forced value.
    logic [15:0]   tbl_bits;
    logic          use_tbl;
    logic          force_pt;

    assign pht_pre_taken = use_tbl ? tbl_bits[pht_index] : force_pt;

    always #5 clk = ~clk;

    branch_history_ctrl #(
        .HIST_W (HW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .mispredict     (mispredict),
        .pht_index      (pht_index),
        .pht_update_en  (pht_update_en),
        .pht_real_taken (pht_real_taken),
        .pht_pre_taken  (pht_pre_taken),
        .q_err          (q_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain queue of in-flight branches plus two histories.
    typedef struct {
        logic [HW-1:0] idx;
        logic          pt;
    } ment_t;

    ment_t         mq[$];
    logic [HW-1:0] m_spec;
    logic [HW-1:0] m_arch;
    logic          m_mis;
    logic          m_qerr;

    logic          o_ready, o_pt, o_upd, o_real, o_mis, o_qerr;
    logic [HW-1:0] o_idx;
    logic          e_ready, e_pt, e_upd, e_real, e_mis, e_qerr;
    logic [HW-1:0] e_idx;

    task automatic model_reset();
        mq.delete();
        m_spec = '0;
        m_arch = '0;
        m_mis  = 1'b0;
        m_qerr = 1'b0;
    endtask

    task automatic apply_reset();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        rst        = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: drive inputs, capture outputs and model expectations mid-cycle,
    // then advance the model across the rising edge.
    task automatic cycle(input logic pv, input logic rv, input logic rt);
        logic          resolving;
        logic          acc;
        logic          nxt_mis;
        logic [HW-1:0] new_arch;
        ment_t         h;
        pred_valid = pv;
        res_valid  = rv;
        res_taken  = rt;
        @(negedge clk);
        o_ready = pred_ready;
        o_pt    = pred_taken;
        o_idx   = pht_index;
        o_upd   = pht_update_en;
        o_real  = pht_real_taken;
        o_mis   = mispredict;
        o_qerr  = q_err;
        resolving = rv && (mq.size() > 0);
        e_idx   = resolving ? mq[0].idx : m_spec;
        e_upd   = resolving;
        e_real  = resolving && rt;
        e_ready = !rv && !m_mis && (mq.size() < DEPTH);
        e_pt    = use_tbl ? tbl_bits[e_idx] : force_pt;
        e_mis   = m_mis;
        e_qerr  = m_qerr;
        acc     = pv && e_ready;
        @(posedge clk);
        #1;
        nxt_mis = 1'b0;
        if (acc) begin
            mq.push_back('{idx: m_spec, pt: e_pt});
            m_spec = {m_spec[HW-2:0], e_pt};
        end
        if (resolving) begin
            h        = mq.pop_front();
            new_arch = {m_arch[HW-2:0], rt};
            m_arch   = new_arch;
            if (rt != h.pt) begin
                mq.delete();
                m_spec  = new_arch;
                nxt_mis = 1'b1;
            end
        end else if (rv) begin
            m_qerr = 1'b1;
        end
        m_mis = nxt_mis;
    endtask

    task automatic test_reset();
        apply_reset();
        cycle(1'b0, 1'b0, 1'b0);
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", o_ready); end
        n_cmp++; if (o_idx !== 4'd0) begin n_bad++; $display("FAIL reset_index got %0d want 0", o_idx); end
        n_cmp++; if (o_upd !== 1'b0) begin n_bad++; $display("FAIL reset_upd got %b want 0", o_upd); end
        n_cmp++; if (o_mis !== 1'b0) begin n_bad++; $display("FAIL reset_mis got %b want 0", o_mis); end
        n_cmp++; if (o_qerr !== 1'b0) begin n_bad++; $display("FAIL reset_qerr got %b want 0", o_qerr); end
        n_cmp++; if (dut.q_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", dut.q_count); end
    endtask

    task automatic test_predict_run();
        logic [HW-1:0] want_idx [3];
        want_idx[0] = 4'd0;
        want_idx[1] = 4'd1;
        want_idx[2] = 4'd3;
        apply_reset();
        use_tbl  = 1'b0;
        force_pt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL run_ready[%0d] got %b want 1", i, o_ready); end
            n_cmp++; if (o_pt !== 1'b1) begin n_bad++; $display("FAIL run_pred_taken[%0d] got %b want 1", i, o_pt); end
            n_cmp++; if (o_idx !== want_idx[i]) begin n_bad++; $display("FAIL run_index[%0d] got %0d want %0d", i, o_idx, want_idx[i]); end
        end
        cycle(1'b0, 1'b0, 1'b0);
        n_cmp++; if (o_idx !== 4'b0111) begin n_bad++; $display("FAIL run_spec_ghr got %b want 0111", o_idx); end
        n_cmp++; if (dut.q_count !== 3'd3) begin n_bad++; $display("FAIL run_count got %0d want 3", dut.q_count); end
    endtask

    task automatic test_full();
        apply_reset();
        use_tbl  = 1'b0;
        force_pt = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", o_ready); end
        n_cmp++; if (dut.q_count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d want 4", dut.q_count); end
        cycle(1'b0, 1'b1, 1'b1);
        n_cmp++; if (o_upd !== 1'b1) begin n_bad++; $display("FAIL full_resolve_upd got %b want 1", o_upd); end
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL full_freed_ready got %b want 1", o_ready); end
        n_cmp++; if (o_mis !== 1'b0) begin n_bad++; $display("FAIL full_mis got %b want 0", o_mis); end
    endtask

    task automatic test_resolve_hit();
        apply_reset();
        use_tbl  = 1'b0;
        force_pt = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        n_cmp++; if (o_idx !== 4'd0) begin n_bad++; $display("FAIL hit_index got %0d want 0", o_idx); end
        n_cmp++; if (o_upd !== 1'b1) begin n_bad++; $display("FAIL hit_upd got %b want 1", o_upd); end
        n_cmp++; if (o_real !== 1'b1) begin n_bad++; $display("FAIL hit_real got %b want 1", o_real); end
        cycle(1'b0, 1'b0, 1'b0);
        n_cmp++; if (o_mis !== 1'b0) begin n_bad++; $display("FAIL hit_mis got %b want 0", o_mis); end
        n_cmp++; if (dut.arch_ghr !== 4'b0001) begin n_bad++; $display("FAIL hit_arch got %b want 0001", dut.arch_ghr); end
    endtask

    task automatic test_mispredict();
        apply_reset();
        use_tbl  = 1'b0;
        force_pt = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        n_cmp++; if (o_upd !== 1'b1) begin n_bad++; $display("FAIL mp_upd got %b want 1", o_upd); end
        n_cmp++; if (o_idx !== 4'd1) begin n_bad++; $display("FAIL mp_index got %0d want 1", o_idx); end
        n_cmp++; if (o_real !== 1'b0) begin n_bad++; $display("FAIL mp_real got %b want 0", o_real); end
        n_cmp++; if (dut.q_count !== 3'd0) begin n_bad++; $display("FAIL mp_count got %0d want 0", dut.q_count); end
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++; if (o_mis !== 1'b1) begin n_bad++; $display("FAIL mp_pulse got %b want 1", o_mis); end
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL mp_ready_pulse got %b want 0", o_ready); end
        n_cmp++; if (o_idx !== 4'b0010) begin n_bad++; $display("FAIL mp_repaired_ghr got %b want 0010", o_idx); end
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++; if (o_mis !== 1'b0) begin n_bad++; $display("FAIL mp_pulse_end got %b want 0", o_mis); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL mp_ready_after got %b want 1", o_ready); end
        n_cmp++; if (dut.q_count !== 3'd1) begin n_bad++; $display("FAIL mp_refill_count got %0d want 1", dut.q_count); end
    endtask

    task automatic test_collision();
        apply_reset();
        use_tbl  = 1'b0;
        force_pt = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL coll_ready got %b want 0", o_ready); end
        n_cmp++; if (o_idx !== 4'd0) begin n_bad++; $display("FAIL coll_index got %0d want 0", o_idx); end
        n_cmp++; if (o_upd !== 1'b1) begin n_bad++; $display("FAIL coll_upd got %b want 1", o_upd); end
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL coll_retry_ready got %b want 1", o_ready); end
        n_cmp++; if (o_idx !== 4'd1) begin n_bad++; $display("FAIL coll_retry_index got %0d want 1", o_idx); end
        n_cmp++; if (dut.q_count !== 3'd1) begin n_bad++; $display("FAIL coll_count got %0d want 1", dut.q_count); end
    endtask

    task automatic test_qerr_reset();
        apply_reset();
        use_tbl  = 1'b0;
        force_pt = 1'b1;
        cycle(1'b0, 1'b1, 1'b1);
        n_cmp++; if (o_upd !== 1'b0) begin n_bad++; $display("FAIL qerr_upd got %b want 0", o_upd); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            n_cmp++; if (o_qerr !== 1'b1) begin n_bad++; $display("FAIL qerr_sticky[%0d] got %b want 1", i, o_qerr); end
        end
        // Scenario 0: reset with entries in flight; scenario 1: reset during the mispredict pulse.
        for (int s = 0; s < 2; s++) begin
            if (s == 1) begin
                cycle(1'b0, 1'b1, 1'b1);
                cycle(1'b0, 1'b1, 1'b0);
                n_cmp++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL rst_pre_mis got %b want 1", mispredict); end
            end
            #2;
            rst = 1'b1;
            #1;
            n_cmp++; if (dut.q_count !== 3'd0) begin n_bad++; $display("FAIL rst_async_count[%0d] got %0d want 0", s, dut.q_count); end
            n_cmp++; if (dut.spec_ghr !== 4'd0) begin n_bad++; $display("FAIL rst_async_spec[%0d] got %b want 0", s, dut.spec_ghr); end
            n_cmp++; if (mispredict !== 1'b0) begin n_bad++; $display("FAIL rst_async_mis[%0d] got %b want 0", s, mispredict); end
            n_cmp++; if (q_err !== 1'b0) begin n_bad++; $display("FAIL rst_async_qerr[%0d] got %b want 0", s, q_err); end
            #1;
            rst = 1'b0;
            model_reset();
            @(posedge clk);
            #1;
            if (s == 0) begin
                for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_random();
        logic pv, rv, rt;
        apply_reset();
        use_tbl  = 1'b1;
        tbl_bits = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 2) == 0);
            rt = 1'($urandom_range(0, 1));
            cycle(pv, rv, rt);
            n_cmp++; if (o_ready !== e_ready) begin n_bad++; $display("FAIL rnd_ready@%0d got %b want %b", i, o_ready, e_ready); end
            n_cmp++; if (o_idx !== e_idx) begin n_bad++; $display("FAIL rnd_index@%0d got %0d want %0d", i, o_idx, e_idx); end
            n_cmp++; if (o_upd !== e_upd) begin n_bad++; $display("FAIL rnd_upd@%0d got %b want %b", i, o_upd, e_upd); end
            n_cmp++; if (o_real !== e_real) begin n_bad++; $display("FAIL rnd_real@%0d got %b want %b", i, o_real, e_real); end
            n_cmp++; if (o_mis !== e_mis) begin n_bad++; $display("FAIL rnd_mis@%0d got %b want %b", i, o_mis, e_mis); end
            n_cmp++; if (o_qerr !== e_qerr) begin n_bad++; $display("FAIL rnd_qerr@%0d got %b want %b", i, o_qerr, e_qerr); end
            if (e_ready) begin
                n_cmp++; if (o_pt !== e_pt) begin n_bad++; $display("FAIL rnd_pred_taken@%0d got %b want %b", i, o_pt, e_pt); end
            end
            n_cmp++; if (dut.q_count !== 3'(mq.size())) begin n_bad++; $display("FAIL rnd_count@%0d got %0d want %0d", i, dut.q_count, mq.size()); end
            n_cmp++; if (dut.arch_ghr !== m_arch) begin n_bad++; $display("FAIL rnd_arch@%0d got %b want %b", i, dut.arch_ghr, m_arch); end
        end
    endtask

    initial begin
        use_tbl  = 1'b0;
        force_pt = 1'b0;
        tbl_bits = '0;
        test_reset();
        test_predict_run();
        test_full();
        test_resolve_hit();
        test_mispredict();
        test_collision();
        test_qerr_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
